// File: rtl/term_frame_pipe.sv
// Fabric-edge terminal tile: retimes the frame chain, owns TermFrames config frames, and drives an N->S loopback.
// Optional macro TERM_LOOP_REG_EN registers S_out, which adds one cycle of loopback latency.
module term_frame_pipe #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int PipeStages      = 1,
    parameter int TermFrames      = 2,
    parameter int LoopWidth       = 32
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    output logic [MaxFramesPerCol-1:0] FrameStrobe_O,
    input  logic [LoopWidth-1:0]       N_in,
    output logic [LoopWidth-1:0]       S_out,
    output logic                       ConfigDone
);
    localparam int CfgBits = TermFrames * FrameBitsPerRow;

    generate
        if (PipeStages < 0 || PipeStages > 3) begin : g_bad_pipe
            $error("term_frame_pipe: PipeStages must be 0..3");
        end
        if (TermFrames < 1 || TermFrames > 4 || TermFrames > MaxFramesPerCol) begin : g_bad_frames
            $error("term_frame_pipe: TermFrames must be 1..4 and fit in FrameStrobe");
        end
        if (2 * LoopWidth > CfgBits) begin : g_bad_loop
            $error("term_frame_pipe: 2*LoopWidth exceeds owned configuration bits");
        end
    endgenerate

    // Frame chain retiming; data and strobe share the same depth to stay aligned.
    generate
        if (PipeStages == 0) begin : g_no_pipe
            assign FrameData_O   = FrameData;
            assign FrameStrobe_O = FrameStrobe;
        end else begin : g_pipe
            for (genvar gi = 0; gi < PipeStages; gi++) begin : g_stage
                logic [FrameBitsPerRow-1:0] data_reg;
                logic [MaxFramesPerCol-1:0] strobe_reg;
                logic [FrameBitsPerRow-1:0] data_next;
                logic [MaxFramesPerCol-1:0] strobe_next;

                if (gi == 0) begin : g_first
                    assign data_next   = FrameData;
                    assign strobe_next = FrameStrobe;
                end else begin : g_later
                    assign data_next   = g_stage[gi-1].data_reg;
                    assign strobe_next = g_stage[gi-1].strobe_reg;
                end

                always_ff @(posedge CLK or posedge reset) begin
                    if (reset) begin
                        data_reg   <= '0;
                        strobe_reg <= '0;
                    end else begin
                        data_reg   <= data_next;
                        strobe_reg <= strobe_next;
                    end
                end
            end
            assign FrameData_O   = g_stage[PipeStages-1].data_reg;
            assign FrameStrobe_O = g_stage[PipeStages-1].strobe_reg;
        end
    endgenerate

    // Owned frames load from the local (unretimed) FrameData on strobe rising edges.
    logic [TermFrames-1:0] strb_q_reg;
    logic [TermFrames-1:0] written_reg;
    logic [TermFrames-1:0] capture;
    logic [CfgBits-1:0]    cfg_flat;

    assign capture = FrameStrobe[TermFrames-1:0] & ~strb_q_reg;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            strb_q_reg  <= '0;
            written_reg <= '0;
        end else begin
            strb_q_reg  <= FrameStrobe[TermFrames-1:0];
            written_reg <= written_reg | capture;
        end
    end

    generate
        for (genvar gi = 0; gi < TermFrames; gi++) begin : g_frame
            logic [FrameBitsPerRow-1:0] cfg_reg;

            always_ff @(posedge CLK or posedge reset) begin
                if (reset) begin
                    cfg_reg <= '0;
                end else if (capture[gi]) begin
                    cfg_reg <= FrameData;
                end
            end

            assign cfg_flat[gi*FrameBitsPerRow +: FrameBitsPerRow] = cfg_reg;
        end
    endgenerate

    assign ConfigDone = &written_reg;

    // Wire k uses config bit pair {invert, enable} at positions {2k+1, 2k}.
    logic [LoopWidth-1:0] loop_comb;

    generate
        for (genvar gi = 0; gi < LoopWidth; gi++) begin : g_wire
            assign loop_comb[gi] = cfg_flat[2*gi] & (N_in[gi] ^ cfg_flat[2*gi+1]);
        end
    endgenerate

    // High configuration bits beyond the loopback map are intentionally ignored.
    logic unused_cfg_parity;
    assign unused_cfg_parity = ^cfg_flat;

`ifdef TERM_LOOP_REG_EN
    logic [LoopWidth-1:0] s_out_reg;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            s_out_reg <= '0;
        end else begin
            s_out_reg <= loop_comb;
        end
    end

    assign S_out = s_out_reg;
`else
    assign S_out = loop_comb;
`endif

endmodule
